// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared definitions for the fetch-stage controller.
// Holds the fetch FSM state encoding, the reset and jump enable levels, and
// the redirect-source priority encoding used by pc_redirect_sel.
package pc_fetch_ctrl_pkg;

    // Fetch handshake states: idle, request on the bus, waiting for response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Active level of the asynchronous reset
    localparam logic RST_ENABLE  = 1'b0;
    // Level of pc_jump_en_o that makes the PC register load pc_jump_addr_o
    localparam logic JUMP_ENABLE = 1'b1;

    // Redirect sources, trap highest priority, then EX branch, then ID jump
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_JMP  = 2'd1,
        REDIR_BR   = 2'd2,
        REDIR_TRAP = 2'd3
    } redir_src_e;

    // Picks the winning redirect source from the three request lines
    function automatic redir_src_e redir_winner(input logic trap_en,
                                                input logic br_en,
                                                input logic jmp_en);
        redir_src_e src;
        if (trap_en)     src = REDIR_TRAP;
        else if (br_en)  src = REDIR_BR;
        else if (jmp_en) src = REDIR_JMP;
        else             src = REDIR_NONE;
        return src;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// pc_redirect_sel: combinational priority select of the redirect target and
// the pipeline flush requests for the fetch controller.
// With PC_FETCH_CTRL_MISALIGN_EN defined it also flags a winning target whose
// two low address bits are not zero.
module pc_redirect_sel
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              trap_en,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              jmp_en,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              redir,
    output logic [ADDR_W-1:0] target,
    output logic              flush_ifid,
`ifdef PC_FETCH_CTRL_MISALIGN_EN
    output logic              misalign,
`endif
    output logic              flush_idex
);

    redir_src_e src;

    // Select the winning target; trap and branch also squash ID/EX
    always_comb begin
        src        = redir_winner(trap_en, br_en, jmp_en);
        target     = '0;
        case (src)
            REDIR_TRAP: target = trap_addr;
            REDIR_BR:   target = br_addr;
            REDIR_JMP:  target = jmp_addr;
            default:    target = '0;
        endcase
        redir      = (src != REDIR_NONE);
        flush_ifid = redir;
        flush_idex = trap_en | br_en;
`ifdef PC_FETCH_CTRL_MISALIGN_EN
        misalign   = redir & (target[1:0] != 2'b00);
`endif
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage controller. Drives the PC register (load/hold/
// increment), runs a one-outstanding req/gnt/rvalid fetch handshake and keeps
// a one-entry instruction buffer for IF/ID, killing responses made stale by a
// redirect.
// Optional feature: define PC_FETCH_CTRL_MISALIGN_EN to add misalign_o; a
// misaligned winning redirect target then holds the PC instead of loading it.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr_i,
    output logic              pc_jump_en_o,
    output logic [ADDR_W-1:0] pc_jump_addr_o,
    input  logic              trap_en_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              br_en_i,
    input  logic [ADDR_W-1:0] br_addr_i,
    input  logic              jmp_en_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    input  logic              stall_i,
    output logic              if_req_o,
    output logic [ADDR_W-1:0] if_addr_o,
    input  logic              if_gnt_i,
    input  logic              if_rvalid_i,
    input  logic [INST_W-1:0] if_rdata_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              flush_ifid_o,
`ifdef PC_FETCH_CTRL_MISALIGN_EN
    output logic              misalign_o,
`endif
    output logic              flush_idex_o
);

    logic              redir;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_flush_ifid;
    logic              redir_flush_idex;
`ifdef PC_FETCH_CTRL_MISALIGN_EN
    logic              redir_misalign;
`endif

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic              kill;
    logic              buf_vld;
    logic [INST_W-1:0] buf_inst;
    logic [ADDR_W-1:0] buf_pc;
    logic [ADDR_W-1:0] req_addr;

    logic              rst_inactive;
    logic              buf_consumed;
    logic              launch_ok;
    logic              launch;
    logic              rsp_take;

    pc_redirect_sel #(
        .ADDR_W (ADDR_W)
    ) u_redirect_sel (
        .trap_en    (trap_en_i),
        .trap_addr  (trap_addr_i),
        .br_en      (br_en_i),
        .br_addr    (br_addr_i),
        .jmp_en     (jmp_en_i),
        .jmp_addr   (jmp_addr_i),
        .redir      (redir),
        .target     (redir_target),
        .flush_ifid (redir_flush_ifid),
`ifdef PC_FETCH_CTRL_MISALIGN_EN
        .misalign   (redir_misalign),
`endif
        .flush_idex (redir_flush_idex)
    );

    assign rst_inactive = (rst_n != RST_ENABLE);

    // The buffer drains whenever the pipeline is not held, so a new fetch may
    // start in the same cycle the buffered instruction leaves.
    assign buf_consumed = buf_vld & ~stall_i;
    assign launch_ok    = ~stall_i & ~redir & (~buf_vld | buf_consumed);

    // A response is kept only if no redirect has overtaken it
    assign rsp_take     = (state == WAIT) & if_rvalid_i & ~kill & ~redir;

    // Next-state logic of the fetch handshake and the launch strobe
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        case (state)
            IDLE: begin
                if (launch_ok) begin
                    launch    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (if_gnt_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (if_rvalid_i) begin
                    if (launch_ok) begin
                        launch    = 1'b1;
                        state_nxt = REQ;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // PC control: redirect loads the target, launch lets the PC increment,
    // every other cycle reloads the current PC to hold it
    always_comb begin
        pc_jump_en_o   = JUMP_ENABLE;
        pc_jump_addr_o = pc_addr_i;
        if (!rst_inactive) begin
            pc_jump_en_o = ~JUMP_ENABLE;
        end else if (redir) begin
`ifdef PC_FETCH_CTRL_MISALIGN_EN
            if (!redir_misalign) pc_jump_addr_o = redir_target;
`else
            pc_jump_addr_o = redir_target;
`endif
        end else if (launch) begin
            pc_jump_en_o = ~JUMP_ENABLE;
        end
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Kill marks the in-flight fetch as stale after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill <= 1'b0;
        end else begin
            case (state)
                REQ:  if (redir) kill <= 1'b1;
                WAIT: begin
                    if (if_rvalid_i) kill <= 1'b0;
                    else if (redir)  kill <= 1'b1;
                end
                default: kill <= kill;
            endcase
        end
    end

    // Capture the PC of each launched request; held on the bus until granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      req_addr <= '0;
        else if (launch) req_addr <= pc_addr_i;
    end

    // One-entry instruction buffer: redirect clears, refill wins over drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld  <= 1'b0;
            buf_inst <= '0;
            buf_pc   <= '0;
        end else if (redir) begin
            buf_vld  <= 1'b0;
        end else if (rsp_take) begin
            buf_vld  <= 1'b1;
            buf_inst <= if_rdata_i;
            buf_pc   <= req_addr;
        end else if (!stall_i) begin
            buf_vld  <= 1'b0;
        end
    end

    assign if_req_o     = (state == REQ);
    assign if_addr_o    = req_addr;
    assign inst_valid_o = buf_vld;
    assign inst_o       = buf_inst;
    assign inst_pc_o    = buf_pc;
    assign flush_ifid_o = rst_inactive & redir_flush_ifid;
    assign flush_idex_o = rst_inactive & redir_flush_idex;
`ifdef PC_FETCH_CTRL_MISALIGN_EN
    assign misalign_o   = rst_inactive & redir_misalign;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: self-checking bench for pc_fetch_ctrl. Directed scenarios
// followed by randomized traffic compared against a transaction-level model.
// Define PC_FETCH_CTRL_MISALIGN_EN to also exercise misalign_o.
module tb_pc_fetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] pc_addr_i;
    logic              pc_jump_en_o;
    logic [ADDR_W-1:0] pc_jump_addr_o;
    logic              trap_en_i, br_en_i, jmp_en_i, stall_i;
    logic [ADDR_W-1:0] trap_addr_i, br_addr_i, jmp_addr_i;
    logic              if_req_o;
    logic [ADDR_W-1:0] if_addr_o;
    logic              if_gnt_i, if_rvalid_i;
    logic [INST_W-1:0] if_rdata_i;
    logic              inst_valid_o;
    logic [INST_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_pc_o;
    logic              flush_ifid_o, flush_idex_o;
`ifdef PC_FETCH_CTRL_MISALIGN_EN
    logic              misalign_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // PC register of the surrounding core: load when enabled, else +4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            pc_addr_i <= '0;
        else if (pc_jump_en_o) pc_addr_i <= pc_jump_addr_o;
        else                   pc_addr_i <= pc_addr_i + 32'd4;
    end

    pc_fetch_ctrl #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_addr_i      (pc_addr_i),
        .pc_jump_en_o   (pc_jump_en_o),
        .pc_jump_addr_o (pc_jump_addr_o),
        .trap_en_i      (trap_en_i),
        .trap_addr_i    (trap_addr_i),
        .br_en_i        (br_en_i),
        .br_addr_i      (br_addr_i),
        .jmp_en_i       (jmp_en_i),
        .jmp_addr_i     (jmp_addr_i),
        .stall_i        (stall_i),
        .if_req_o       (if_req_o),
        .if_addr_o      (if_addr_o),
        .if_gnt_i       (if_gnt_i),
        .if_rvalid_i    (if_rvalid_i),
        .if_rdata_i     (if_rdata_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .flush_ifid_o   (flush_ifid_o),
`ifdef PC_FETCH_CTRL_MISALIGN_EN
        .misalign_o     (misalign_o),
`endif
        .flush_idex_o   (flush_idex_o)
    );

    task automatic drive(input bit t, input bit b, input bit j,
                         input bit s, input bit g, input bit r);
        trap_en_i   = t;
        br_en_i     = b;
        jmp_en_i    = j;
        stall_i     = s;
        if_gnt_i    = g;
        if_rvalid_i = r;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n       = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        trap_addr_i = 32'h100;
        br_addr_i   = 32'h200;
        jmp_addr_i  = 32'h300;
        if_rdata_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        trap_addr_i = 32'h100;
        br_addr_i   = 32'h200;
        jmp_addr_i  = 32'h300;
        if_rdata_i  = 32'hFFFF_FFFF;
        drive(1, 1, 1, 0, 1, 1);
        next_cycle();
        #4;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL reset_jump_en: got %b, expected 0", pc_jump_en_o); end
        checks++; if (pc_jump_addr_o !== pc_addr_i) begin errors++; $display("FAIL reset_jump_addr: got %h, expected %h", pc_jump_addr_o, pc_addr_i); end
        checks++; if (if_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", if_req_o); end
        checks++; if (if_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", if_addr_o); end
        checks++; if ({inst_valid_o, inst_o, inst_pc_o} !== 65'h0) begin errors++; $display("FAIL reset_buffer: got %b/%h/%h, expected zeros", inst_valid_o, inst_o, inst_pc_o); end
        checks++; if ({flush_ifid_o, flush_idex_o} !== 2'b00) begin errors++; $display("FAIL reset_flush: got %b, expected 00", {flush_ifid_o, flush_idex_o}); end
        // reset asserted while a fetch waits for its response
        apply_reset();
        drive(0, 0, 0, 0, 1, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b0;
        #1;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL midreset_jump_en: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
        rst_n      = 1'b1;
        if_rdata_i = 32'hBAD0_BAD0;
        drive(0, 0, 0, 1, 0, 1);
        #4;
        checks++; if (if_req_o !== 1'b0) begin errors++; $display("FAIL midreset_req: got %b, expected 0", if_req_o); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL midreset_rsp_ignored: got %b, expected 0", inst_valid_o); end
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL midreset_idle_launch: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
    endtask

    task automatic test_stream;
        logic [31:0] e_addr, e_ipc;
        bit          e_req, e_v;
        apply_reset();
        drive(0, 0, 0, 0, 1, 1);
        for (int k = 0; k < 9; k++) begin
            if_rdata_i = 32'hC0DE_0000 + 32'(2 * k) - 32'd4;
            #4;
            e_req  = (k % 2 == 1);
            e_addr = 32'(2 * k) - 32'd2;
            e_v    = (k >= 3) && (k % 2 == 1);
            e_ipc  = 32'(2 * k) - 32'd6;
            checks++; if (if_req_o !== e_req) begin errors++; $display("FAIL stream_req[%0d]: got %b, expected %b", k, if_req_o, e_req); end
            if (e_req) begin
                checks++; if (if_addr_o !== e_addr) begin errors++; $display("FAIL stream_addr[%0d]: got %h, expected %h", k, if_addr_o, e_addr); end
            end
            checks++; if (inst_valid_o !== e_v) begin errors++; $display("FAIL stream_valid[%0d]: got %b, expected %b", k, inst_valid_o, e_v); end
            if (e_v) begin
                checks++; if (inst_pc_o !== e_ipc) begin errors++; $display("FAIL stream_ipc[%0d]: got %h, expected %h", k, inst_pc_o, e_ipc); end
                checks++; if (inst_o !== 32'hC0DE_0000 + e_ipc) begin errors++; $display("FAIL stream_inst[%0d]: got %h, expected %h", k, inst_o, 32'hC0DE_0000 + e_ipc); end
            end
            checks++; if (pc_jump_en_o !== e_req) begin errors++; $display("FAIL stream_jump_en[%0d]: got %b, expected %b", k, pc_jump_en_o, e_req); end
            next_cycle();
        end
    endtask

    task automatic test_stall;
        apply_reset();
        if_rdata_i = 32'h1234_5678;
        drive(0, 0, 0, 0, 1, 1);
        next_cycle();
        next_cycle();
        drive(0, 0, 0, 1, 1, 1);
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            if_rdata_i = 32'hDEAD_0000 + 32'(i);
            #4;
            checks++; if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h1234_5678, 32'h0}) begin errors++; $display("FAIL stall_buffer[%0d]: got %b/%h/%h, expected 1/12345678/0", i, inst_valid_o, inst_o, inst_pc_o); end
            checks++; if ({pc_jump_en_o, pc_jump_addr_o} !== {1'b1, 32'h4}) begin errors++; $display("FAIL stall_hold[%0d]: got %b/%h, expected 1/4", i, pc_jump_en_o, pc_jump_addr_o); end
            checks++; if (if_req_o !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b, expected 0", i, if_req_o); end
            next_cycle();
        end
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL unstall_launch: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
        #4;
        checks++; if ({if_req_o, if_addr_o, inst_valid_o} !== {1'b1, 32'h4, 1'b0}) begin errors++; $display("FAIL unstall_req: got %b/%h/%b, expected 1/4/0", if_req_o, if_addr_o, inst_valid_o); end
        next_cycle();
    endtask

    task automatic test_priority;
        apply_reset();
        drive(1, 1, 1, 0, 0, 0);
        #4;
        checks++; if ({pc_jump_en_o, pc_jump_addr_o} !== {1'b1, 32'h100}) begin errors++; $display("FAIL prio_trap: got %b/%h, expected 1/100", pc_jump_en_o, pc_jump_addr_o); end
        checks++; if ({flush_ifid_o, flush_idex_o} !== 2'b11) begin errors++; $display("FAIL prio_trap_flush: got %b, expected 11", {flush_ifid_o, flush_idex_o}); end
        next_cycle();
        drive(0, 1, 1, 0, 0, 0);
        #4;
        checks++; if ({pc_jump_addr_o, flush_ifid_o, flush_idex_o} !== {32'h200, 2'b11}) begin errors++; $display("FAIL prio_br: got %h/%b%b, expected 200/11", pc_jump_addr_o, flush_ifid_o, flush_idex_o); end
        next_cycle();
        drive(0, 0, 1, 0, 0, 0);
        #4;
        checks++; if ({pc_jump_addr_o, flush_ifid_o, flush_idex_o} !== {32'h300, 2'b10}) begin errors++; $display("FAIL prio_jmp: got %h/%b%b, expected 300/10", pc_jump_addr_o, flush_ifid_o, flush_idex_o); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL prio_relaunch: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
        #4;
        checks++; if ({if_req_o, if_addr_o} !== {1'b1, 32'h300}) begin errors++; $display("FAIL prio_req_addr: got %b/%h, expected 1/300", if_req_o, if_addr_o); end
        next_cycle();
    endtask

    task automatic test_jmp_wait;
        apply_reset();
        jmp_addr_i = 32'h40;
        drive(0, 0, 0, 0, 1, 0);
        next_cycle();
        next_cycle();
        drive(0, 0, 1, 0, 1, 0);
        #4;
        checks++; if ({pc_jump_en_o, pc_jump_addr_o} !== {1'b1, 32'h40}) begin errors++; $display("FAIL jmpwait_target: got %b/%h, expected 1/40", pc_jump_en_o, pc_jump_addr_o); end
        checks++; if ({flush_ifid_o, flush_idex_o} !== 2'b10) begin errors++; $display("FAIL jmpwait_flush: got %b, expected 10", {flush_ifid_o, flush_idex_o}); end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0);
        next_cycle();
        if_rdata_i = 32'hBAD0_0001;
        drive(0, 0, 0, 0, 1, 1);
        #4;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL jmpwait_launch: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++; if ({inst_valid_o, if_req_o, if_addr_o} !== {2'b01, 32'h40}) begin errors++; $display("FAIL jmpwait_discard: got %b/%b/%h, expected 0/1/40", inst_valid_o, if_req_o, if_addr_o); end
        next_cycle();
        if_rdata_i = 32'h600D_0040;
        drive(0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++; if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h600D_0040, 32'h40}) begin errors++; $display("FAIL jmpwait_next: got %b/%h/%h, expected 1/600d0040/40", inst_valid_o, inst_o, inst_pc_o); end
        next_cycle();
    endtask

    task automatic test_br_req;
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 1, 0, 0, 0, 0);
        #4;
        checks++; if ({if_req_o, if_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL brreq_keep: got %b/%h, expected 1/0", if_req_o, if_addr_o); end
        checks++; if ({pc_jump_addr_o, flush_idex_o} !== {32'h200, 1'b1}) begin errors++; $display("FAIL brreq_target: got %h/%b, expected 200/1", pc_jump_addr_o, flush_idex_o); end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, (i == 2), 0);
            #4;
            checks++; if ({if_req_o, if_addr_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL brreq_stable[%0d]: got %b/%h, expected 1/0", i, if_req_o, if_addr_o); end
            next_cycle();
        end
        if_rdata_i = 32'hBAD0_0002;
        drive(0, 0, 0, 0, 0, 1);
        #4;
        checks++; if (pc_jump_en_o !== 1'b0) begin errors++; $display("FAIL brreq_launch: got %b, expected 0", pc_jump_en_o); end
        next_cycle();
        drive(0, 0, 0, 0, 1, 0);
        #4;
        checks++; if ({inst_valid_o, if_addr_o} !== {1'b0, 32'h200}) begin errors++; $display("FAIL brreq_killed: got %b/%h, expected 0/200", inst_valid_o, if_addr_o); end
        next_cycle();
        if_rdata_i = 32'h600D_0200;
        drive(0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
        #4;
        checks++; if ({inst_valid_o, inst_pc_o} !== {1'b1, 32'h200}) begin errors++; $display("FAIL brreq_kill_cleared: got %b/%h, expected 1/200", inst_valid_o, inst_pc_o); end
        next_cycle();
    endtask

`ifdef PC_FETCH_CTRL_MISALIGN_EN
    task automatic test_misalign;
        apply_reset();
        br_addr_i = 32'h102;
        drive(0, 1, 0, 0, 0, 0);
        #4;
        checks++; if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_flag: got %b, expected 1", misalign_o); end
        checks++; if ({pc_jump_en_o, pc_jump_addr_o} !== {1'b1, pc_addr_i}) begin errors++; $display("FAIL misalign_hold: got %b/%h, expected 1/%h", pc_jump_en_o, pc_jump_addr_o, pc_addr_i); end
        checks++; if ({flush_ifid_o, flush_idex_o} !== 2'b11) begin errors++; $display("FAIL misalign_flush: got %b, expected 11", {flush_ifid_o, flush_idex_o}); end
        br_addr_i = 32'h200;
        #1;
        checks++; if ({misalign_o, pc_jump_addr_o} !== {1'b0, 32'h200}) begin errors++; $display("FAIL aligned_br: got %b/%h, expected 0/200", misalign_o, pc_jump_addr_o); end
        next_cycle();
        drive(0, 0, 0, 0, 0, 0);
    endtask
`endif

    // Randomized traffic checked against a transaction-level model
    task automatic test_random;
        bit          m_req, m_rsp, m_stale, m_bv;
        logic [31:0] m_bd, m_bpc, m_raddr;
        bit          t, b, j, s, g, r, e_redir, e_start, e_jen, e_deliver;
        logic [31:0] e_tgt, e_jaddr;
        apply_reset();
        m_req = 0; m_rsp = 0; m_stale = 0; m_bv = 0;
        m_bd = '0; m_bpc = '0; m_raddr = '0;
        for (int n = 0; n < 3000; n++) begin
            t = ($urandom_range(0, 99) < 5);
            b = ($urandom_range(0, 99) < 6);
            j = ($urandom_range(0, 99) < 8);
            s = ($urandom_range(0, 99) < 20);
            g = ($urandom_range(0, 1) == 1);
            r = m_rsp && ($urandom_range(0, 1) == 1);
            trap_addr_i = 32'($urandom_range(0, 1023)) << 2;
            br_addr_i   = 32'($urandom_range(0, 1023)) << 2;
            jmp_addr_i  = 32'($urandom_range(0, 1023)) << 2;
            if_rdata_i  = $urandom;
            drive(t, b, j, s, g, r);
            #4;
            e_redir = t | b | j;
            e_tgt   = t ? trap_addr_i : (b ? br_addr_i : jmp_addr_i);
            e_start = !s && !e_redir && ((!m_req && !m_rsp) || (m_rsp && r));
            e_jen   = e_redir || !e_start;
            e_jaddr = e_redir ? e_tgt : pc_addr_i;
            checks++; if (if_req_o !== m_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b, expected %b", n, if_req_o, m_req); end
            if (m_req) begin
                checks++; if (if_addr_o !== m_raddr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h, expected %h", n, if_addr_o, m_raddr); end
            end
            checks++; if (pc_jump_en_o !== e_jen) begin errors++; $display("FAIL rnd_jump_en[%0d]: got %b, expected %b", n, pc_jump_en_o, e_jen); end
            checks++; if (pc_jump_addr_o !== e_jaddr) begin errors++; $display("FAIL rnd_jump_addr[%0d]: got %h, expected %h", n, pc_jump_addr_o, e_jaddr); end
            checks++; if ({flush_ifid_o, flush_idex_o} !== {e_redir, t | b}) begin errors++; $display("FAIL rnd_flush[%0d]: got %b%b, expected %b%b", n, flush_ifid_o, flush_idex_o, e_redir, t | b); end
            checks++; if (inst_valid_o !== m_bv) begin errors++; $display("FAIL rnd_valid[%0d]: got %b, expected %b", n, inst_valid_o, m_bv); end
            if (m_bv) begin
                checks++; if ({inst_o, inst_pc_o} !== {m_bd, m_bpc}) begin errors++; $display("FAIL rnd_inst[%0d]: got %h/%h, expected %h/%h", n, inst_o, inst_pc_o, m_bd, m_bpc); end
            end
            // advance the model to the next cycle
            e_deliver = r && !m_stale && !e_redir;
            if (e_redir)        m_bv = 0;
            else if (e_deliver) begin m_bv = 1; m_bd = if_rdata_i; m_bpc = m_raddr; end
            else if (!s)        m_bv = 0;
            if (r)                             m_stale = 0;
            else if ((m_req || m_rsp) && e_redir) m_stale = 1;
            if (r) m_rsp = 0;
            if (m_req && g) begin m_req = 0; m_rsp = 1; end
            if (e_start) begin m_req = 1; m_raddr = pc_addr_i; end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_priority();
        test_jmp_wait();
        test_br_req();
`ifdef PC_FETCH_CTRL_MISALIGN_EN
        test_misalign();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Fetch-stage controller that sequences the PC register and the instruction-memory fetch port.
- Drives PC control:
  - Selects the next-PC redirect source: trap, EX branch, or ID jump.
  - Holds the PC during stalls by re-loading the current PC through the PC jump port, since the PC register has no enable.
- Runs a one-outstanding request/grant/response fetch handshake.
- Buffers one fetched instruction for the IF/ID stage and kills stale responses after a redirect.

Parameters:
- ADDR_W, 32, PC and fetch address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_addr_i  in  ADDR_W  current PC from the PC register.
- pc_jump_en_o  out  1  PC load enable; PC increments by 4 when low.
- pc_jump_addr_o  out  ADDR_W  PC load value.
- trap_en_i  in  1  trap redirect request.
- trap_addr_i  in  ADDR_W  trap target.
- br_en_i  in  1  EX-stage branch redirect request.
- br_addr_i  in  ADDR_W  branch target.
- jmp_en_i  in  1  ID-stage jump redirect request.
- jmp_addr_i  in  ADDR_W  jump target.
- stall_i  in  1  pipeline hold from the hazard unit.
- if_req_o  out  1  fetch request.
- if_addr_o  out  ADDR_W  fetch address; stable while if_req_o=1 and not yet granted.
- if_gnt_i  in  1  request accepted.
- if_rvalid_i  in  1  response valid; arrives in or after the cycle following the grant.
- if_rdata_i  in  INST_W  response data.
- inst_valid_o  out  1  buffered instruction valid.
- inst_o  out  INST_W  buffered instruction.
- inst_pc_o  out  ADDR_W  address of the buffered instruction.
- flush_ifid_o  out  1  flush the IF/ID register.
- flush_idex_o  out  1  flush the ID/EX register.

Behaviour:
- Reset:
  - State goes to IDLE; kill, buf_vld and req_addr clear to 0.
  - All outputs are 0 during reset, except pc_jump_addr_o, which follows pc_addr_i.
- Redirect (combinational, same cycle):
  - redir = trap_en_i | br_en_i | jmp_en_i.
  - Priority: trap > br > jmp. Only the winning target drives pc_jump_addr_o, with pc_jump_en_o=1.
  - flush_ifid_o = redir.
  - flush_idex_o = trap_en_i | br_en_i.
- PC advance:
  - With no redirect, pc_jump_en_o=0 only in a cycle where a new request is launched (launch = IDLE->REQ, or WAIT->REQ).
  - In every other cycle, pc_jump_en_o=1 and pc_jump_addr_o=pc_addr_i (hold).
- Launch condition: !stall_i & !redir & (buf_vld==0 | buffer consumed this cycle).
  - On launch, req_addr <= pc_addr_i.
- FSM states IDLE, REQ, WAIT:
  - IDLE: on launch -> REQ; otherwise stay in IDLE.
  - REQ: if_req_o=1, if_addr_o=req_addr.
    - if_gnt_i -> WAIT.
    - A redirect while in REQ must not drop or alter the request; it sets kill.
  - WAIT: on if_rvalid_i:
    - If kill or redir in that cycle: discard the response and clear kill.
    - Otherwise: buf_vld<=1, inst_o<=if_rdata_i, inst_pc_o<=req_addr.
    - Then -> REQ if the launch condition holds (back-to-back), else -> IDLE.
    - A redirect in WAIT without rvalid sets kill.
- Buffer (one entry):
  - inst_valid_o = buf_vld.
  - Consumed in any cycle with stall_i=0; buf_vld clears unless refilled in the same cycle.
  - Held unchanged while stall_i=1.
  - redir clears buf_vld next cycle; redir has precedence over a refill.
- Simultaneous events:
  - redir in the same cycle as rvalid: the response is dropped and kill is not set.
  - stall_i and redir together: the redirect wins for the PC and the flushes; no launch occurs.
- Throughput: at most one instruction per 2 cycles with single-cycle grant and response.
- Reset mid-transaction: the FSM aborts immediately; a response after reset release is ignored because the state is IDLE.

Optional Feature:
- Macro: PC_FETCH_CTRL_MISALIGN_EN.
- When defined:
  - Adds output misalign_o.
  - A winning redirect target with addr[1:0]!=0 asserts misalign_o for that cycle (combinational).
  - The PC is held, not loaded, and flushes still assert.
- When undefined:
  - No port is added; targets are loaded unchecked.

Decomposition:
- Shared defines file: fetch FSM state encodings, RST_ENABLE/JUMP_ENABLE, and the redirect priority encoding.
- One sub-module, pc_redirect_sel:
  - Purely combinational priority select of the target and the flush signals.
  - Also contains the misalignment check.
- The FSM and the buffer stay in the top module.

Test Plan:
- Reset release, then gnt/rvalid=1 every cycle with pc_addr_i tracking:
  - if_addr_o sequence 0x0, 0x4, 0x8.
  - inst_valid_o pulses with inst_pc_o matching each address.
  - Issue rate is one instruction per 2 cycles.
- stall_i=1 for 3 cycles while buf_vld=1:
  - inst_o and inst_pc_o are held.
  - pc_jump_en_o=1 with the hold address.
  - if_req_o=0 from IDLE.
- trap_en_i, br_en_i and jmp_en_i all asserted in one cycle with targets 0x100/0x200/0x300:
  - pc_jump_addr_o=0x100.
  - flush_ifid_o=1 and flush_idex_o=1.
- jmp_en_i only, to 0x40, while in WAIT; rvalid arrives 2 cycles later:
  - The response is discarded (inst_valid_o stays 0).
  - flush_idex_o=0.
  - The next request address is 0x40.
- br_en_i while in REQ with gnt delayed 3 cycles:
  - if_addr_o is stable until the grant.
  - The granted response is killed.
  - kill clears after rvalid.
- With PC_FETCH_CTRL_MISALIGN_EN, br_addr_i=0x102:
  - misalign_o=1.
  - pc_jump_addr_o equals the current PC.
